// File: rtl/mem_access_unit.sv
// Load/store access sequencer: lane masking, store alignment, load extension and response timeout.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of forcing them aligned.
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          load,
  input  logic          store,
  input  logic [2:0]    fun3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   op_b,
  input  logic          data_valid,
  input  logic [31:0]   wrap_load_in,
  output logic          request,
  output logic          we_re,
  output logic [3:0]    mask,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   store_data_out,
  output logic [31:0]   wrap_load_out,
  output logic          done,
  output logic          stall,
  output logic          err_timeout,
  output logic          err_misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    fun3_reg;
  logic [AW-1:0] mem_addr_reg;
  logic          we_re_reg;
  logic [3:0]    mask_reg;
  logic [31:0]   store_data_reg;
  logic [31:0]   wrap_load_reg;
  logic          err_timeout_reg;

  logic          accept;
  logic          is_half;
  logic          is_word;
  logic          trap;
  logic [1:0]    lane;
  logic [3:0]    mask_next;
  logic [31:0]   store_data_next;
  logic [31:0]   load_shifted;
  logic [31:0]   load_ext;
  logic          timeout_hit;

  assign accept  = (state_reg == IDLE) && valid && (load || store);
  assign is_half = (fun3[1:0] == 2'b01);
  assign is_word = fun3[1];

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_misalign_reg;
  assign trap = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign lane = addr[1:0];
`else
  // Misaligned low address bits are dropped so the access lands on its natural boundary.
  assign trap = 1'b0;
  assign lane = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
`endif

  always_comb begin
    mask_next       = 4'b1111;
    store_data_next = op_b;
    case (fun3[1:0])
      2'b00: begin
        mask_next       = 4'b0001 << lane;
        store_data_next = op_b << {lane, 3'b000};
      end
      2'b01: begin
        mask_next       = 4'b0011 << {lane[1], 1'b0};
        store_data_next = op_b << {lane[1], 4'b0000};
      end
      default: begin
        mask_next       = 4'b1111;
        store_data_next = op_b;
      end
    endcase
  end

  // Load data is realigned from the captured lane before extension.
  always_comb begin
    load_shifted = wrap_load_in;
    if (!fun3_reg[1]) begin
      if (fun3_reg[0])
        load_shifted = wrap_load_in >> {mem_addr_reg[1], 4'b0000};
      else
        load_shifted = wrap_load_in >> {mem_addr_reg[1:0], 3'b000};
    end
    case (fun3_reg)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_ext = {24'd0, load_shifted[7:0]};
      3'b101:  load_ext = {16'd0, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (state_reg == WAIT) && !data_valid &&
                       (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = trap ? DONE : WAIT;
      WAIT: if (data_valid || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      fun3_reg        <= 3'd0;
      mem_addr_reg    <= '0;
      we_re_reg       <= 1'b0;
      mask_reg        <= 4'd0;
      store_data_reg  <= 32'd0;
      wrap_load_reg   <= 32'd0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      err_timeout_reg <= timeout_hit;
      if (accept) begin
        cnt_reg        <= '0;
        fun3_reg       <= fun3;
        mem_addr_reg   <= {addr[AW-1:2], lane};
        we_re_reg      <= store;
        mask_reg       <= mask_next;
        store_data_reg <= store_data_next;
      end else if ((state_reg == WAIT) && (TIMEOUT != 0)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((state_reg == WAIT) && data_valid && !we_re_reg)
        wrap_load_reg <= load_ext;
      else if (timeout_hit)
        wrap_load_reg <= 32'd0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) err_misalign_reg <= 1'b0;
    else     err_misalign_reg <= accept && trap;
  end
  assign err_misalign = err_misalign_reg;
`else
  assign err_misalign = 1'b0;
`endif

  assign request        = (state_reg == WAIT);
  assign done           = (state_reg == DONE);
  assign stall          = (state_reg != IDLE) || accept;
  assign we_re          = we_re_reg;
  assign mask           = mask_reg;
  assign mem_addr       = mem_addr_reg;
  assign store_data_out = store_data_reg;
  assign wrap_load_out  = wrap_load_reg;
  assign err_timeout    = err_timeout_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (AW=32, TIMEOUT=16).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, load = 1'b0, store = 1'b0;
  logic [2:0]  fun3 = 3'd0;
  logic [31:0] addr = 32'd0, op_b = 32'd0;
  logic        data_valid = 1'b0;
  logic [31:0] wrap_load_in = 32'd0;
  logic        request, we_re, done, stall, err_timeout, err_misalign;
  logic [3:0]  mask;
  logic [31:0] mem_addr, store_data_out, wrap_load_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] maddr;
    logic [31:0] sdata;
    logic        we;
    logic [31:0] res;
    logic        to;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.AW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid(valid), .load(load), .store(store), .fun3(fun3),
    .addr(addr), .op_b(op_b), .data_valid(data_valid), .wrap_load_in(wrap_load_in),
    .request(request), .we_re(we_re), .mask(mask), .mem_addr(mem_addr),
    .store_data_out(store_data_out), .wrap_load_out(wrap_load_out), .done(done),
    .stall(stall), .err_timeout(err_timeout), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: drive, push expectation, wait (bounded) for done, pop and compare.
  task automatic access(input string name, input logic st, input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input int dly,
                        input logic [31:0] rdata, input logic noise, input exp_t e);
    exp_t        x;
    int          cycles;
    int          reqc;
    logic [3:0]  mask_w;
    logic [31:0] sdata_w;
    valid = 1'b1; store = st; load = ld; fun3 = f3; addr = a; op_b = b;
    #1;
    check({name, ":stall_accept"}, stall, 1);
    sb.push_back(e);
    tick();
    valid = 1'b0; store = 1'b0; load = 1'b0;
    check({name, ":request"}, request, 1);
    mask_w  = mask;
    sdata_w = store_data_out;
    cycles  = 0;
    reqc    = 0;
    while (done !== 1'b1 && cycles < 40) begin
      data_valid   = (cycles == dly);
      wrap_load_in = rdata;
      if (noise) begin
        valid = 1'b1; store = 1'b1; addr = 32'hFFFF_FFFC; op_b = 32'h5555_5555; fun3 = 3'b010;
      end
      if (request === 1'b1) reqc++;
      tick();
      cycles++;
    end
    data_valid = 1'b0;
    valid = 1'b0; store = 1'b0;
    x = sb.pop_front();
    check({name, ":done"}, done, 1);
    check({name, ":latency"}, cycles, x.lat);
    check({name, ":req_cycles"}, reqc, x.lat);
    check({name, ":mask_wait"}, mask_w, x.mask);
    check({name, ":mask"}, mask, x.mask);
    check({name, ":sdata_wait"}, sdata_w, x.sdata);
    check({name, ":sdata"}, store_data_out, x.sdata);
    check({name, ":mem_addr"}, mem_addr, x.maddr);
    check({name, ":we_re"}, we_re, x.we);
    check({name, ":result"}, wrap_load_out, x.res);
    check({name, ":err_timeout"}, err_timeout, x.to);
    check({name, ":err_misalign"}, err_misalign, 0);
    check({name, ":stall_done"}, stall, 1);
    $display("txn %s lat=%0d mask=%b addr=%h sdata=%h res=%h to=%b",
             name, cycles, mask, mem_addr, store_data_out, wrap_load_out, err_timeout);
    tick();
    check({name, ":done_drop"}, done, 0);
    check({name, ":stall_idle"}, stall, 0);
    check({name, ":err_timeout_drop"}, err_timeout, 0);
  endtask

  initial begin
    int done_seen;
    repeat (3) tick();
    check("rst:request", request, 0);
    check("rst:done", done, 0);
    check("rst:mask", mask, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:sdata", store_data_out, 0);
    check("rst:result", wrap_load_out, 0);
    check("rst:we_re", we_re, 0);
    check("rst:stall", stall, 0);
    check("rst:errs", {err_timeout, err_misalign}, 0);
    rst = 1'b0;
    tick();

    access("SW_100", 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0,
           exp_t'{4'b1111, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1});
    access("LB_103", 0, 1, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000, 0,
           exp_t'{4'b1000, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0, 1});
    access("LBU_103", 0, 1, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, 0,
           exp_t'{4'b1000, 32'h103, 32'h0, 1'b0, 32'h0000_0080, 1'b0, 1});
    access("SH_102", 1, 0, 3'b001, 32'h102, 32'h1234, 0, 32'hFFFF_FFFF, 0,
           exp_t'{4'b1100, 32'h102, 32'h1234_0000, 1'b1, 32'h0000_0080, 1'b0, 1});
    access("LH_102", 0, 1, 3'b001, 32'h102, 32'h0, 3, 32'h8001_0000, 0,
           exp_t'{4'b1100, 32'h102, 32'h0, 1'b0, 32'hFFFF_8001, 1'b0, 4});
    access("LHU_100_noise", 0, 1, 3'b101, 32'h100, 32'h0, 2, 32'h0000_8001, 1,
           exp_t'{4'b0011, 32'h100, 32'h0, 1'b0, 32'h0000_8001, 1'b0, 3});
    access("SB_101", 1, 0, 3'b000, 32'h101, 32'h0000_00AB, 0, 32'h0, 0,
           exp_t'{4'b0010, 32'h101, 32'h0000_AB00, 1'b1, 32'h0000_8001, 1'b0, 1});
    access("LDST_both", 1, 1, 3'b010, 32'h200, 32'h1122_3344, 0, 32'h0, 0,
           exp_t'{4'b1111, 32'h200, 32'h1122_3344, 1'b1, 32'h0000_8001, 1'b0, 1});
    access("LW_104", 0, 1, 3'b010, 32'h104, 32'h0, 1, 32'hCAFE_F00D, 0,
           exp_t'{4'b1111, 32'h104, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 2});
    access("LW_timeout", 0, 1, 3'b010, 32'h108, 32'h0, -1, 32'h1234_5678, 0,
           exp_t'{4'b1111, 32'h108, 32'h0, 1'b0, 32'h0, 1'b1, 16});

`ifdef MEM_MISALIGN_TRAP_EN
    valid = 1'b1; load = 1'b1; fun3 = 3'b001; addr = 32'h101;
    #1;
    check("trap:stall", stall, 1);
    tick();
    valid = 1'b0; load = 1'b0;
    check("trap:done", done, 1);
    check("trap:err_misalign", err_misalign, 1);
    check("trap:request", request, 0);
    tick();
    check("trap:done_drop", done, 0);
    check("trap:err_drop", err_misalign, 0);
    $display("txn LH_101_trap");
`else
    access("LH_101_misal", 0, 1, 3'b001, 32'h101, 32'h0, 0, 32'hABCD_1234, 0,
           exp_t'{4'b0011, 32'h100, 32'h0, 1'b0, 32'h0000_1234, 1'b0, 1});
    access("SW_103_misal", 1, 0, 3'b010, 32'h103, 32'hA5A5_0F0F, 0, 32'h0, 0,
           exp_t'{4'b1111, 32'h100, 32'hA5A5_0F0F, 1'b1, 32'h0000_1234, 1'b0, 1});
`endif

    // Responses arriving while idle must be ignored.
    data_valid = 1'b1; wrap_load_in = 32'hDEAD_BEEF;
    tick();
    tick();
    data_valid = 1'b0;
    check("idle_dv:request", request, 0);
    check("idle_dv:done", done, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("idle_dv:result", wrap_load_out, 32'h0);
`else
    check("idle_dv:result", wrap_load_out, 32'h0000_1234);
`endif
    $display("txn idle_data_valid res=%h", wrap_load_out);

    // Reset during WAIT aborts with no done.
    valid = 1'b1; load = 1'b1; fun3 = 3'b010; addr = 32'h300;
    tick();
    valid = 1'b0; load = 1'b0;
    check("rst_wait:request_before", request, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait:request", request, 0);
    check("rst_wait:stall", stall, 0);
    check("rst_wait:mem_addr", mem_addr, 0);
    check("rst_wait:result", wrap_load_out, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      data_valid = (i == 2);
      if (done === 1'b1) done_seen++;
      tick();
    end
    data_valid = 1'b0;
    check("rst_wait:no_done", done_seen, 0);
    $display("txn reset_in_wait done_seen=%0d", done_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter AW, default 32: address width in bits, minimum 3.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles to wait for a response; 0 disables the timeout.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: valid  in  1  instruction valid; load  in  1  load op; store  in  1  store op; fun3  in  3  instruction[14:12].
REQ-005 SHALL have ports: addr  in  AW  byte address; op_b  in  32  store source.
REQ-006 SHALL have ports: data_valid  in  1  memory response; wrap_load_in  in  32  memory read data.
REQ-007 SHALL have ports: request  out  1  memory request; we_re  out  1  1 = write; mask  out  4  byte-lane enables; mem_addr  out  AW  captured address; store_data_out  out  32  lane-aligned write data.
REQ-008 SHALL have ports: wrap_load_out  out  32  extended load result; done  out  1  one-cycle completion; stall  out  1  hold upstream; err_timeout  out  1; err_misalign  out  1.
REQ-009 SHALL use one clock, clk, with rst synchronous and active-high.

Function
REQ-010 SHALL implement a state machine with states IDLE, WAIT and DONE.
REQ-011 SHALL accept an access in IDLE when valid & (load | store); store has priority when both are high.
REQ-012 SHALL register on accept: addr, we_re = store, fun3, the lane-shifted op_b and the mask; next state WAIT.
REQ-013 SHALL generate the mask from fun3[1:0] and addr[1:0]: 00 gives 4'b0001<<addr[1:0]; 01 gives 4'b0011<<(2*addr[1]); 10 or 11 gives 4'b1111.
REQ-014 SHALL shift store data left by the same lane offset: 8*addr[1:0] for bytes, 16*addr[1] for halfwords, none for words.
REQ-015 SHALL drive request=1 combinationally in WAIT only; mask, mem_addr, store_data_out and we_re SHALL remain stable throughout WAIT.
REQ-016 SHALL, in WAIT, on data_valid=1 capture the shifted and extended wrap_load_in into wrap_load_out and go to DONE; for stores, wrap_load_out SHALL be unchanged.
REQ-017 SHALL extend loads by fun3: 000 sign-extends bits [7:0]; 001 sign-extends [15:0]; 010 passes the word; 100 zero-extends [7:0]; 101 zero-extends [15:0]; other codes pass the word.
REQ-018 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-019 SHALL set stall = (state != IDLE) | (IDLE & accept); stall SHALL be low in DONE-exit cycle only when state returns to IDLE.
REQ-020 SHALL meet minimum latency: accept at edge N, request high cycle N+1, data_valid in that same cycle, done high cycle N+2.
REQ-021 SHALL count WAIT cycles when TIMEOUT != 0; after TIMEOUT cycles with no data_valid it SHALL drop request, set err_timeout=1, set wrap_load_out=0 and go to DONE.
REQ-022 SHALL clear the cycle counter on every entry into WAIT.
REQ-023 SHALL ignore data_valid in IDLE and DONE, and SHALL ignore valid outside IDLE.
REQ-024 SHALL hold err_timeout and err_misalign high only in DONE; both are 0 otherwise.
REQ-025 SHALL define misalignment as a halfword with addr[0]=1, or a word with addr[1:0] != 0.

Reset
REQ-026 SHALL, on rst, enter IDLE and set request, we_re, mask, done, err_timeout, err_misalign, wrap_load_out, store_data_out, mem_addr and the counter to 0.
REQ-027 SHALL abort a WAIT on rst, with request low from the following cycle and no done generated.

Configuration
REQ-028 SHALL use macro MEM_MISALIGN_TRAP_EN.
REQ-029 SHALL, when MEM_MISALIGN_TRAP_EN is defined, send a misaligned access directly from IDLE to DONE with err_misalign=1, issuing no request.
REQ-030 SHALL, when MEM_MISALIGN_TRAP_EN is undefined, force the offending low address bits to 0 (mem_addr, mask and shifts alike), proceed normally, and tie err_misalign to 0.

Verification
REQ-031 SHALL cover: SW addr=0x100, op_b=0xDEADBEEF, data_valid one cycle after request -> mask=1111, we_re=1, store_data_out=0xDEADBEEF, done on cycle N+2.
REQ-032 SHALL cover: LB addr=0x103, wrap_load_in=0x80FF_0000 -> mask=1000, wrap_load_out=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-033 SHALL cover: SH addr=0x102, op_b=0x1234 -> mask=1100, store_data_out=0x12340000.
REQ-034 SHALL cover: LW with TIMEOUT=16 and no data_valid -> request high for 16 cycles, then done=1, err_timeout=1, wrap_load_out=0.
REQ-035 SHALL cover: LH addr=0x101 -> with the macro, done+err_misalign next cycle and no request; without it, mem_addr=0x100 and mask=0011.
REQ-036 SHALL cover: rst asserted in WAIT -> next cycle request=0, state IDLE, done never asserted.
